ray_plane_seq: RTL and testbench

Sequential ray-plane intersection engine for the ray tracer core.
- Accepts one ray/plane job per valid/ready handshake.
- Computes numerator and denominator dot products with one shared pair of multipliers, then divides for t using the team's clocked divide_module.
- Forms p_hit = origin + dir*t one component per cycle and holds the result until accepted.
- Replaces the combinational intersect path wherever a clocked divider is required.

---
 rtl/ray_pkg.sv | 15 +
 rtl/divide_module.sv | 72 +++++++
 rtl/ray_plane_seq.sv | 171 +++++++++++++++++
 tb/tb_ray_plane_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types and constants for the ray-plane intersection engine.
// Signed fixed-point words with Q_BITS_DEF fractional bits.
package ray_pkg;

    localparam int Q_BITS_DEF  = 10;
    localparam int D_WIDTH_DEF = 32;

    typedef logic signed [D_WIDTH_DEF-1:0] fix_t;
    typedef fix_t [0:2] vec3_t;

    typedef enum logic [2:0] {IDLE, DOT, CHECK, DIV, SCALE, OUT} rp_state_t;

    localparam fix_t FIX_ONE = fix_t'(1 << Q_BITS_DEF);

endpackage

// File: rtl/divide_module.sv
// Clocked signed divider: restoring, one quotient bit per cycle, truncating toward zero.
// The dividend is expected to be a D_WIDTH word scaled by 2^Q_BITS, so only D_WIDTH+Q_BITS bits are iterated.
module divide_module #(
    parameter int Q_BITS   = 10,
    parameter int D_WIDTH  = 32,
    parameter int ED_WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       valid_in,
    input  logic signed [ED_WIDTH-1:0] dividend,
    input  logic signed [D_WIDTH-1:0]  divisor,
    output logic                       valid_out,
    output logic signed [ED_WIDTH-1:0] quotient
);

    localparam int ITERS = D_WIDTH + Q_BITS;
    localparam int CW    = $clog2(ITERS);

    logic                    busy_q, done_q, neg_q;
    logic [CW-1:0]           cnt_q;
    logic [D_WIDTH-1:0]      rem_q;
    logic [ITERS-1:0]        wq_q;
    logic [D_WIDTH:0]        dmag_q;
    logic [ITERS-1:0]        dd_mag;
    logic signed [D_WIDTH:0] dv_ext;
    logic [D_WIDTH:0]        dv_mag;
    logic [D_WIDTH:0]        rs;
    logic                    take;
    logic [ED_WIDTH-1:0]     q_ext;

    assign dd_mag = ITERS'(dividend[ED_WIDTH-1] ? -dividend : dividend);
    assign dv_ext = {divisor[D_WIDTH-1], divisor};
    assign dv_mag = dv_ext[D_WIDTH] ? -dv_ext : dv_ext;
    assign rs     = {rem_q, wq_q[ITERS-1]};
    assign take   = (rs >= dmag_q);
    assign q_ext  = {{(ED_WIDTH-ITERS){1'b0}}, wq_q};

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            wq_q   <= '0;
            dmag_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (valid_in) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                rem_q  <= '0;
                wq_q   <= dd_mag;
                dmag_q <= dv_mag;
                neg_q  <= dividend[ED_WIDTH-1] ^ divisor[D_WIDTH-1];
            end else if (busy_q) begin
                rem_q <= take ? D_WIDTH'(rs - dmag_q) : D_WIDTH'(rs);
                wq_q  <= {wq_q[ITERS-2:0], take};
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(ITERS-1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign valid_out = done_q;
    assign quotient  = neg_q ? -$signed(q_ext) : $signed(q_ext);

endmodule

// File: rtl/ray_plane_seq.sv
// Sequential ray-plane intersection: shared multiplier pair, clocked divide for t, serial p_hit.
// Optional RAY_T_NEG_REJECT_EN: a negative t clears out_hit (t and p_hit still reported).
import ray_pkg::*;

module ray_plane_seq #(
    parameter int Q_BITS  = Q_BITS_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  in_valid,
    output logic  in_ready,
    input  vec3_t in_normal,
    input  vec3_t in_v0,
    input  vec3_t in_origin,
    input  vec3_t in_dir,
    output logic  out_valid,
    input  logic  out_ready,
    output vec3_t out_p_hit,
    output fix_t  out_t,
    output logic  out_hit
);

    localparam int P_WIDTH = 2 * D_WIDTH;

    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // valid/ready are registered and valid never drops before its transfer.
    rp_state_t state_q, state_d;
    logic [1:0] k_q, k_d;
    vec3_t n_q, v0_q, org_q, dir_q;
    vec3_t p_q, p_d;
    fix_t  num_q, num_d, den_q, den_d, t_q, t_d;
    logic  hit_q, hit_d, rdy_q, vld_q;
    logic  div_start, div_done;
    logic signed [P_WIDTH-1:0] dividend, div_quot;
    logic signed [P_WIDTH-1:0] prod_ab, prod_cd;
    fix_t  mul_a, mul_b, mul_c, mul_d;
    fix_t  sh_ab, sh_cd, diff, q_trunc;

    assign diff     = v0_q[k_q] - org_q[k_q];
    assign prod_ab  = $signed({{D_WIDTH{mul_a[D_WIDTH-1]}}, mul_a}) * $signed({{D_WIDTH{mul_b[D_WIDTH-1]}}, mul_b});
    assign prod_cd  = $signed({{D_WIDTH{mul_c[D_WIDTH-1]}}, mul_c}) * $signed({{D_WIDTH{mul_d[D_WIDTH-1]}}, mul_d});
    assign sh_ab    = D_WIDTH'(prod_ab >>> Q_BITS);
    assign sh_cd    = D_WIDTH'(prod_cd >>> Q_BITS);
    assign dividend = $signed({{D_WIDTH{num_q[D_WIDTH-1]}}, num_q}) <<< Q_BITS;
    assign q_trunc  = D_WIDTH'(div_quot);

    divide_module #(
        .Q_BITS  (Q_BITS),
        .D_WIDTH (D_WIDTH),
        .ED_WIDTH(P_WIDTH)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .valid_in (div_start),
        .dividend (dividend),
        .divisor  (den_q),
        .valid_out(div_done),
        .quotient (div_quot)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        num_d     = num_q;
        den_d     = den_q;
        t_d       = t_q;
        hit_d     = hit_q;
        p_d       = p_q;
        div_start = 1'b0;
        mul_a     = n_q[k_q];
        mul_b     = diff;
        mul_c     = n_q[k_q];
        mul_d     = dir_q[k_q];
        case (state_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    num_d   = '0;
                    den_d   = '0;
                    k_d     = 2'd0;
                    state_d = DOT;
                end
            end
            DOT: begin
                num_d = num_q + sh_ab;
                den_d = den_q + sh_cd;
                k_d   = k_q + 2'd1;
                if (k_q == 2'd2) begin
                    k_d     = 2'd0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (den_q == '0) begin
                    t_d     = '0;
                    hit_d   = 1'b0;
                    state_d = SCALE;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    t_d = q_trunc;
`ifdef RAY_T_NEG_REJECT_EN
                    hit_d = ~q_trunc[D_WIDTH-1];
`else
                    hit_d = 1'b1;
`endif
                    state_d = SCALE;
                end
            end
            SCALE: begin
                // Second multiplier idles here; the first scales dir by t.
                mul_a    = dir_q[k_q];
                mul_b    = t_q;
                p_d[k_q] = org_q[k_q] + sh_ab;
                k_d      = k_q + 2'd1;
                if (k_q == 2'd2) begin
                    k_d     = 2'd0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            num_q   <= '0;
            den_q   <= '0;
            t_q     <= '0;
            hit_q   <= 1'b0;
            p_q     <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            num_q   <= num_d;
            den_q   <= den_d;
            t_q     <= t_d;
            hit_q   <= hit_d;
            p_q     <= p_d;
            rdy_q   <= (state_d == IDLE);
            vld_q   <= (state_d == OUT);
        end
    end

    always_ff @(posedge clock) begin
        if (in_valid && rdy_q) begin
            n_q   <= in_normal;
            v0_q  <= in_v0;
            org_q <= in_origin;
            dir_q <= in_dir;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_t     = t_q;
    assign out_hit   = hit_q;
    assign out_p_hit = p_q;

endmodule

// File: tb/tb_ray_plane_seq.sv
// Bench for ray_plane_seq: directed cases, backpressure, mid-job reset, back-to-back and random jobs.
module tb_ray_plane_seq;
    import ray_pkg::*;

    logic  clock = 1'b0;
    logic  reset = 1'b0;
    logic  in_valid = 1'b0;
    logic  out_ready = 1'b0;
    logic  in_ready, out_valid, out_hit;
    vec3_t in_normal = '0, in_v0 = '0, in_origin = '0, in_dir = '0;
    vec3_t out_p_hit;
    fix_t  out_t;

    typedef struct {
        int n[3];
        int v0[3];
        int o[3];
        int d[3];
    } job_t;

    // Expected result packing: {hit, t, p0, p1, p2}
    logic [128:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cyc = 0;
    bit bp_en = 1'b0;

    ray_plane_seq dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_normal(in_normal),
        .in_v0    (in_v0),
        .in_origin(in_origin),
        .in_dir   (in_dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p_hit(out_p_hit),
        .out_t    (out_t),
        .out_hit  (out_hit)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [128:0] model(job_t j);
        int num = 0;
        int den = 0;
        int t;
        int p[3];
        bit hit;
        for (int k = 0; k < 3; k++) begin
            num += int'((longint'(j.n[k]) * longint'(j.v0[k] - j.o[k])) >>> Q_BITS_DEF);
            den += int'((longint'(j.n[k]) * longint'(j.d[k])) >>> Q_BITS_DEF);
        end
        if (den == 0) begin
            t = 0;
            hit = 1'b0;
        end else begin
            t = int'((longint'(num) <<< Q_BITS_DEF) / longint'(den));
`ifdef RAY_T_NEG_REJECT_EN
            hit = (t >= 0);
`else
            hit = 1'b1;
`endif
        end
        for (int k = 0; k < 3; k++)
            p[k] = j.o[k] + int'((longint'(j.d[k]) * longint'(t)) >>> Q_BITS_DEF);
        return {hit, t, p[0], p[1], p[2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input job_t j);
        int g = 0;
        for (int k = 0; k < 3; k++) begin
            in_normal[k] = j.n[k];
            in_v0[k]     = j.v0[k];
            in_origin[k] = j.o[k];
            in_dir[k]    = j.d[k];
        end
        in_valid = 1'b1;
        while (!in_ready && g < 400) begin
            @(posedge clock); #1;
            g++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end else begin
            @(posedge clock); #1;
            in_valid = 1'b0;
            acc_cyc = cyc;
            exp_q.push_back(model(j));
        end
    endtask

    task automatic drain(input int budget);
        int g = 0;
        while (exp_q.size() != 0 && g < budget) begin
            @(posedge clock);
            g++;
        end
        #1;
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
    endtask

    function automatic job_t mk(int nz, int v0z, int o0, int oz, int d0, int dz);
        job_t j;
        j.n  = '{0, 0, nz};
        j.v0 = '{0, 0, v0z};
        j.o  = '{o0, 0, oz};
        j.d  = '{d0, 0, dz};
        return j;
    endfunction

    function automatic job_t rnd_job();
        job_t j;
        for (int k = 0; k < 3; k++) begin
            j.n[k]  = int'($urandom_range(0, 40000)) - 20000;
            j.v0[k] = int'($urandom_range(0, 40000)) - 20000;
            j.o[k]  = int'($urandom_range(0, 40000)) - 20000;
            j.d[k]  = int'($urandom_range(0, 40000)) - 20000;
        end
        if ($urandom_range(0, 4) == 0) begin
            j.n[0] = 0;
            j.n[1] = 0;
            j.d[2] = 0;
        end
        return j;
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clock) begin
        logic [128:0] e;
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got out_valid=1 t=%0d want no result", out_t);
            end else begin
                e = exp_q[0];
                check("out_t", out_t, e[127:96]);
                check("p_hit0", out_p_hit[0], e[95:64]);
                check("p_hit1", out_p_hit[1], e[63:32]);
                check("p_hit2", out_p_hit[2], e[31:0]);
                check("out_hit", 32'(out_hit), 32'(e[128]));
                check("busy_in_ready", 32'(in_ready), 0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    hs_cyc = cyc;
                end
            end
        end
    end

    always @(posedge clock) begin
        if (bp_en) begin
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        job_t j1, j2, j3, ja;
        logic [128:0] r;
        int n;
        bit exp_hit3;

        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_hit", 32'(out_hit), 0);
        check("rst_out_t", out_t, 0);
        check("rst_p_hit2", out_p_hit[2], 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("ready_after_reset", 32'(in_ready), 1);

        // Plane z=5 hit by an axis ray
        j1 = mk(1024, 5120, 0, 0, 0, 1024);
        r = model(j1);
        check("model_axis_t", r[127:96], 5120);
        check("model_axis_pz", r[31:0], 5120);
        check("model_axis_hit", 32'(r[128]), 1);
        out_ready = 1'b1;
        send(j1);
        drain(200);

        // Parallel ray: no divide, fixed 7-cycle latency
        j2 = mk(1024, 5120, 0, 0, 1024, 0);
        r = model(j2);
        check("model_par_t", r[127:96], 0);
        check("model_par_hit", 32'(r[128]), 0);
        send(j2);
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!out_valid && n < 200);
        check("par_latency", n, 7);
        drain(50);

        // Hit behind the origin
`ifdef RAY_T_NEG_REJECT_EN
        exp_hit3 = 1'b0;
`else
        exp_hit3 = 1'b1;
`endif
        j3 = mk(1024, 5120, 0, 10240, 0, 1024);
        r = model(j3);
        check("model_behind_t", r[127:96], -5120);
        check("model_behind_pz", r[31:0], 5120);
        check("model_behind_hit", 32'(r[128]), 32'(exp_hit3));
        send(j3);
        drain(200);

        // Backpressure: result held, busy-time offers ignored
        out_ready = 1'b0;
        send(j3);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (!out_valid) fail_now("bp_wait");
        repeat (5) begin
            for (int k = 0; k < 3; k++) begin
                in_normal[k] = fix_t'($urandom);
                in_dir[k]    = fix_t'($urandom);
            end
            in_valid = 1'b1;
            @(posedge clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_ready", 32'(in_ready), 1);
        check("bp_release_valid", 32'(out_valid), 0);
        check("bp_queue_empty", exp_q.size(), 0);
        repeat (10) @(posedge clock);
        #1;

        // Reset while the divider is busy
        send(j1);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        check("midrst_ready_low", 32'(in_ready), 0);
        @(posedge clock); #1;
        check("midrst_ready", 32'(in_ready), 1);
        check("midrst_valid", 32'(out_valid), 0);
        repeat (80) @(posedge clock);
        #1;
        send(rnd_job());
        drain(200);

        // Back-to-back: second accept one edge after the first output handshake
        ja = rnd_job();
        send(ja);
        send(j1);
        check("b2b_gap", acc_cyc - hs_cyc, 2);
        drain(200);

        // Random jobs under random backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 25; i++) send(rnd_job());
        bp_en = 1'b0;
        @(posedge clock); #2;
        out_ready = 1'b1;
        drain(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
